// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache main-memory responder.
package dcache_pkg;

    localparam int unsigned BLOCK_BITS  = 256;
    localparam int unsigned ADDR_BITS   = 32;
    localparam int unsigned OFFSET_BITS = 5;

    typedef logic [BLOCK_BITS-1:0] block_t;
    typedef logic [ADDR_BITS-1:0]  addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Byte address to block number; callers keep only the index bits they store.
    function automatic addr_t block_of(addr_t addr);
        return addr >> OFFSET_BITS;
    endfunction

endpackage

// File: rtl/dcache_mem_responder_if.sv
// Block request/response bus between the dcache controller (master) and main memory (slave).
interface dcache_mem_responder_if;
    import dcache_pkg::*;

    addr_t  addr_i;
    block_t data_i;
    logic   enable_i;
    logic   write_i;
    logic   ack_o;
    block_t data_o;

    modport master (
        output addr_i,
        output data_i,
        output enable_i,
        output write_i,
        input  ack_o,
        input  data_o
    );

    modport slave (
        input  addr_i,
        input  data_i,
        input  enable_i,
        input  write_i,
        output ack_o,
        output data_o
    );

endinterface

// File: rtl/dcache_mem_array.sv
// Single-port block RAM: registered read, synchronous write, no reset on contents.
module dcache_mem_array
    import dcache_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  block_t                wdata,
    output block_t                rdata
);

    block_t mem [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/dcache_mem_responder.sv
// Fixed-latency main-memory responder: accepts one block read/write, acks LATENCY cycles later.
module dcache_mem_responder
    import dcache_pkg::*;
#(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    dcache_mem_responder_if.slave   bus
);

    localparam logic [7:0] LOAD = 8'(LATENCY - 2);

    state_e                  state_q, state_d;
    logic [7:0]              count_q, count_d;
    logic [DEPTH_LOG2-1:0]   index_q, index_d;
    block_t                  data_q, data_d;
    logic                    write_q, write_d;
    logic                    mem_we;
    block_t                  mem_rdata;
    addr_t                   req_block;
    logic                    unused_addr;

    assign req_block   = block_of(bus.addr_i);
    assign unused_addr = ^bus.addr_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            index_q <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        data_d  = data_q;
        write_d = write_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    index_d = req_block[DEPTH_LOG2-1:0];
                    data_d  = bus.data_i;
                    write_d = bus.write_i;
                    count_d = LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    state_d = ACK;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            ACK: begin
                // Commit on the ACK->IDLE edge; an async reset leaves ACK first and blocks it.
                mem_we  = write_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The RAM reads the latched index every cycle, so the BUSY->ACK edge captures the block.
    dcache_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk_i (clk_i),
        .we    (mem_we),
        .index (index_q),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

    assign bus.ack_o  = (state_q == ACK);
    assign bus.data_o = (state_q == ACK && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: a LATENCY=10 and a LATENCY=2 instance against a request-level model.
module tb_dcache_mem_responder;
    import dcache_pkg::*;

    localparam int unsigned LAT0 = 10;
    localparam int unsigned LAT1 = 2;
    localparam int unsigned DL0  = 9;
    localparam int unsigned DL1  = 4;

    localparam block_t PAT_A5 = {32{8'hA5}};
    localparam block_t PAT_5A = {32{8'h5A}};
    localparam block_t PAT_B1 = {8{32'h1111_0001}};
    localparam block_t PAT_B2 = {8{32'h2222_0002}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_mem_responder_if bus0 ();
    dcache_mem_responder_if bus1 ();

    logic [31:0] addr_v  [2];
    block_t      wdata_v [2];
    logic        en_v    [2];
    logic        wr_v    [2];
    logic        ack_w   [2];
    block_t      rdat_w  [2];

    assign bus0.addr_i   = addr_v[0];
    assign bus0.data_i   = wdata_v[0];
    assign bus0.enable_i = en_v[0];
    assign bus0.write_i  = wr_v[0];
    assign bus1.addr_i   = addr_v[1];
    assign bus1.data_i   = wdata_v[1];
    assign bus1.enable_i = en_v[1];
    assign bus1.write_i  = wr_v[1];
    assign ack_w[0]  = bus0.ack_o;
    assign rdat_w[0] = bus0.data_o;
    assign ack_w[1]  = bus1.ack_o;
    assign rdat_w[1] = bus1.data_o;

    dcache_mem_responder #(
        .LATENCY    (LAT0),
        .DEPTH_LOG2 (DL0)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    dcache_mem_responder #(
        .LATENCY    (LAT1),
        .DEPTH_LOG2 (DL1)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    // Request-level model: one pending request per instance, acked at accept cycle + latency.
    int     cyc = 0;
    bit     pend    [2];
    int     ack_cyc [2];
    int     pidx    [2];
    bit     pwr     [2];
    block_t pdat    [2];
    block_t mem_m   [2][512];
    bit     known   [2][512];
    int     n_cmp = 0;
    int     n_err = 0;

    function automatic int lat_of(int d);
        return (d == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic int idx_of(int d, logic [31:0] a);
        logic [31:0] mask;
        mask = (32'd1 << ((d == 0) ? DL0 : DL1)) - 32'd1;
        return int'((a >> 5) & mask);
    endfunction

    function automatic void check(int d, string name, block_t act, block_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s cycle %0d: got %h want %h", d, name, cyc, act, exp);
        end
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0; ack_cyc[d] = 0; pidx[d] = 0; pwr[d] = 1'b0; pdat[d] = '0;
            addr_v[d] = '0; wdata_v[d] = '0; en_v[d] = 1'b0; wr_v[d] = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pend[d] = 1'b0;
            end else if (pend[d]) begin
                if (cyc == ack_cyc[d]) begin
                    if (pwr[d]) begin
                        mem_m[d][pidx[d]] = pdat[d];
                        known[d][pidx[d]] = 1'b1;
                    end
                    pend[d] = 1'b0;
                end
            end else if (en_v[d]) begin
                pend[d]    = 1'b1;
                ack_cyc[d] = cyc + lat_of(d);
                pidx[d]    = idx_of(d, addr_v[d]);
                pwr[d]     = wr_v[d];
                pdat[d]    = wdata_v[d];
            end
        end
        cyc = cyc + 1;
    end

    initial forever begin
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit ea;
            ea = !rst && pend[d] && (cyc == ack_cyc[d]);
            check(d, "ack", block_t'(ack_w[d]), block_t'(ea));
            if (ea && !pwr[d]) begin
                if (known[d][pidx[d]]) check(d, "read_data", rdat_w[d], mem_m[d][pidx[d]]);
            end else begin
                check(d, "data_zero", rdat_w[d], '0);
            end
        end
    end

    task automatic do_req(input int d, input logic [31:0] a, input block_t dat, input logic w,
                          input int drop_at, input int toggle_at, input bit scramble,
                          output int lat, output block_t rd);
        int s;
        @(negedge clk);
        s = cyc;
        addr_v[d] = a; wdata_v[d] = dat; wr_v[d] = w; en_v[d] = 1'b1;
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(negedge clk);
            if (ack_w[d]) begin
                lat = cyc - s;
                rd  = rdat_w[d];
                en_v[d] = 1'b0;
            end else begin
                if (drop_at > 0 && k >= drop_at) en_v[d] = 1'b0;
                if (k == toggle_at) wr_v[d] = ~wr_v[d];
                if (scramble) begin
                    addr_v[d]  = $urandom;
                    wdata_v[d] = {8{$urandom}};
                end
            end
        end
        en_v[d] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int     lat, s, c1, c2, n_ack, pairs;
        bit     prev;
        block_t rd;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check(0, "reset_ack", block_t'(ack_w[0]), '0);
        check(0, "reset_data", rdat_w[0], '0);
        check(1, "reset_ack", block_t'(ack_w[1]), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic write then read of block 2
        do_req(0, 32'h0000_0040, PAT_A5, 1'b1, 0, 0, 1'b0, lat, rd);
        check(0, "wr_latency", block_t'(lat), block_t'(10));
        check(0, "wr_ack_data", rd, '0);
        do_req(0, 32'h0000_0040, '0, 1'b0, 0, 0, 1'b0, lat, rd);
        check(0, "rd_latency", block_t'(lat), block_t'(10));
        check(0, "rd_data_a5", rd, PAT_A5);

        // Reset in cycle 5 of a write to block 2 must abort it
        @(negedge clk);
        s = cyc;
        addr_v[0] = 32'h0000_0040; wdata_v[0] = PAT_5A; wr_v[0] = 1'b1; en_v[0] = 1'b1;
        while (cyc < s + 5) @(negedge clk);
        rst = 1'b1;
        en_v[0] = 1'b0;
        #1;
        check(0, "abort_ack", block_t'(ack_w[0]), '0);
        check(0, "abort_data", rdat_w[0], '0);
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 32'h0000_0040, '0, 1'b0, 0, 0, 1'b0, lat, rd);
        check(0, "post_reset_lat", block_t'(lat), block_t'(10));
        check(0, "post_reset_data", rd, PAT_A5);

        // Aliasing onto block 3
        do_req(0, 32'h0000_0060, block_t'(32'h1234), 1'b1, 0, 0, 1'b0, lat, rd);
        do_req(0, 32'h0000_007F, '0, 1'b0, 0, 0, 1'b0, lat, rd);
        check(0, "alias_7f", rd, block_t'(32'h1234));
        do_req(0, 32'hFFFF_C060, '0, 1'b0, 0, 0, 1'b0, lat, rd);
        check(0, "alias_c060", rd, block_t'(32'h1234));

        // Enable dropped from cycle 3
        do_req(0, 32'h0000_0040, '0, 1'b0, 3, 0, 1'b0, lat, rd);
        check(0, "drop_latency", block_t'(lat), block_t'(10));
        check(0, "drop_data", rd, PAT_A5);
        n_ack = 0;
        repeat (15) begin
            @(negedge clk);
            if (ack_w[0]) n_ack++;
        end
        check(0, "no_second_ack", block_t'(n_ack), '0);

        // Back-to-back writes with enable held high
        @(negedge clk);
        s = cyc; c1 = -1; c2 = -1; pairs = 0; prev = 1'b0;
        addr_v[0] = 32'h0000_0020; wdata_v[0] = PAT_B1; wr_v[0] = 1'b1; en_v[0] = 1'b1;
        for (int k = 0; k < 60 && c2 < 0; k++) begin
            @(negedge clk);
            if (ack_w[0] && prev) pairs++;
            prev = ack_w[0];
            if (ack_w[0]) begin
                if (c1 < 0) begin
                    c1 = cyc;
                    addr_v[0] = 32'h0000_0040; wdata_v[0] = PAT_B2;
                end else begin
                    c2 = cyc;
                end
            end
        end
        en_v[0] = 1'b0;
        check(0, "b2b_first_ack", block_t'(c1 - s), block_t'(10));
        check(0, "b2b_second_ack", block_t'(c2 - s), block_t'(21));
        check(0, "b2b_ack_pairs", block_t'(pairs), '0);
        do_req(0, 32'h0000_0020, '0, 1'b0, 0, 0, 1'b0, lat, rd);
        check(0, "b2b_blk1", rd, PAT_B1);
        do_req(0, 32'h0000_0040, '0, 1'b0, 0, 0, 1'b0, lat, rd);
        check(0, "b2b_blk2", rd, PAT_B2);

        // LATENCY=2 instance, write_i toggled during BUSY
        do_req(1, 32'h0000_0020, block_t'(32'hCAFE), 1'b1, 0, 0, 1'b0, lat, rd);
        check(1, "l2_wr_latency", block_t'(lat), block_t'(2));
        do_req(1, 32'h0000_0020, '0, 1'b0, 0, 1, 1'b0, lat, rd);
        check(1, "l2_rd_latency", block_t'(lat), block_t'(2));
        check(1, "l2_rd_toggled", rd, block_t'(32'hCAFE));
        do_req(1, 32'h0000_0020, block_t'(32'hBEEF), 1'b1, 0, 1, 1'b0, lat, rd);
        check(1, "l2_wr_toggled", rd, '0);
        do_req(1, 32'h0000_0020, '0, 1'b0, 0, 0, 1'b0, lat, rd);
        check(1, "l2_rd_after_wr", rd, block_t'(32'hBEEF));

        // Randomized traffic; the compare process checks every cycle
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                block_t      dat;
                a = $urandom;
                if (d == 0) a[13:9] = 5'd0;
                dat = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
                do_req(d, a, dat, 1'($urandom_range(0, 1)), int'($urandom_range(0, lat_of(d))),
                       int'($urandom_range(0, lat_of(d) - 1)), 1'b1, lat, rd);
                check(d, "rand_latency", block_t'(lat), block_t'(lat_of(d)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
